sw_bcd_updown_chain: RTL
========================

Name: sw_bcd_updown_chain

Overview:
Parametrised N-digit packed-BCD up/down counter for the stopwatch/timer datapath. It is the next-generation stopwatch digit counter and supports:
- per-digit rollover limits, so one instance counts mixed radix (e.g. MM:SS);
- count direction select, synchronous load and clear;
- wrap or saturate mode.

It sits between the 1 kHz tick divider and the display/segment mux. CARRY/BORROW drive the next chained stage.

Parameters:
NDIG, 4, number of BCD digits; BCD width = 4*NDIG.
DIGMAX, 16'h5959, packed per-digit maximum value (nibble i = max of digit i, each 1..9).
MAXVAL, 16'h5959, packed upper terminal value. Every nibble <= matching DIGMAX nibble.
SETVAL, 16'h0000, packed reset/clear/lower-terminal value. Legal, and <= MAXVAL.
WRAP, 1, 1 = wrap at terminal; 0 = saturate and hold at terminal.

Ports:
CLK1K  in  1  counter clock.
RST  in  1  asynchronous active-high reset.
EN  in  1  count enable, one step per enabled cycle.
UP  in  1  direction: 1 = increment, 0 = decrement.
CLR  in  1  synchronous clear to SETVAL.
LOAD  in  1  synchronous load of LDVAL.
LDVAL  in  4*NDIG  packed BCD load value.
BCD  out  4*NDIG  registered packed BCD count.
CARRY  out  1  one-cycle pulse on up-wrap MAXVAL->SETVAL.
BORROW  out  1  one-cycle pulse on down-wrap SETVAL->MAXVAL.
TC  out  1  combinational: count is at the terminal for the current direction (UP ? BCD==MAXVAL : BCD==SETVAL).
LDERR  out  1  one-cycle pulse when a LOAD is rejected.

Behaviour:
- Reset (RST=1, asynchronous): BCD=SETVAL; CARRY=0; BORROW=0; LDERR=0. Reset applies immediately, mid-count included.
- Registered outputs: BCD, CARRY, BORROW and LDERR all update on the CLK1K rising edge. A step is visible one cycle after EN is sampled.
- Per-cycle priority: CLR > LOAD > EN. Outputs not named in a case are 0 that cycle.
- CLR: BCD=SETVAL. No pulses.
- LOAD with LDVAL legal: BCD=LDVAL.
  - Legal means every nibble <= its DIGMAX nibble, and SETVAL <= LDVAL <= MAXVAL as unsigned packed values.
- LOAD with LDVAL illegal: BCD unchanged; LDERR=1 for one cycle.
- Idle (EN=0, no CLR/LOAD): BCD holds; pulses 0.
- Up step (EN=1, UP=1, BCD != MAXVAL):
  - Digit 0 increments.
  - A digit equal to its DIGMAX goes to 0 and carries into the next digit.
  - Digit i changes only if all lower digits rolled.
- Up at MAXVAL:
  - WRAP=1: BCD=SETVAL, CARRY=1.
  - WRAP=0: hold, CARRY=0.
- Down step (EN=1, UP=0, BCD != SETVAL):
  - Digit 0 decrements.
  - A digit at 0 goes to its DIGMAX and borrows from the next digit.
- Down at SETVAL:
  - WRAP=1: BCD=MAXVAL, BORROW=1.
  - WRAP=0: hold, BORROW=0.
- A UP change while EN=1 takes effect on that same edge; there is no direction-change latency.
- Invariant: BCD never holds a nibble above its DIGMAX, and never holds a value outside [SETVAL, MAXVAL].
- No state machine beyond the count register. The carry chain is combinational ripple across NDIG digits; NDIG <= 8 closes at 1 kHz trivially.

Decomposition:
- Package sw_bcd_pkg:
  - BCD_W=4 constant.
  - Digit max/zero constants.
  - Function bcd_legal(value, digmax), shared with the load check and the assertions.
  - Function bcd_nib(vec, i) for nibble extraction.
- Sub-module bcd_digit_cell: one digit.
  - Inputs: current value, DIGMAX nibble, UP, step-in.
  - Outputs: next value, step-out (carry/borrow).
  - Instantiated NDIG times in a generate loop.
- Terminal compare, load check and the output registers live in the top.

Test Plan (defaults NDIG=4, DIGMAX=16'h5959, MAXVAL=16'h5959, SETVAL=16'h0000, WRAP=1 unless stated):
- RST pulse mid-count at BCD=16'h0312 -> BCD=16'h0000 immediately. CARRY, BORROW and LDERR are 0 while RST is high.
- LOAD 16'h0059, UP=1, EN one cycle -> BCD=16'h0100. LOAD 16'h5959, EN one cycle -> BCD=16'h0000, CARRY=1 for exactly one cycle.
- From 16'h0000, UP=0, EN one cycle -> BCD=16'h5959, BORROW=1. Next step -> 16'h5958, BORROW=0. LOAD 16'h0100 then down step -> 16'h0059.
- WRAP=0 instance: at 16'h5959, UP=1, EN held 3 cycles -> BCD stays 16'h5959, CARRY=0, TC=1. At 16'h0000 with UP=0 -> holds, TC=1.
- LOAD 16'h0070 (nibble 7 > 5) -> BCD unchanged, LDERR=1 for one cycle. LOAD 16'h1234 -> accepted, LDERR=0.
- Same cycle CLR=1, LOAD=1 (LDVAL 16'h1234), EN=1 at BCD=16'h5959 -> BCD=16'h0000 with no CARRY. LOAD+EN with no CLR -> LDVAL loaded, no step.

Source files
------------

// File: rtl/sw_bcd_updown_chain_pkg.sv
// Shared constants and helpers for the stopwatch BCD counter.
// Nibble access and BCD legality checks used by load logic and assertions.
package sw_bcd_pkg;

  localparam int BCD_W = 4;
  localparam logic [3:0] DIG_ZERO = 4'd0;
  localparam logic [3:0] DIG_NINE = 4'd9;

  function automatic logic [3:0] bcd_nib(
    input logic [31:0] vec,
    input int          i
  );
    return vec[BCD_W*i +: BCD_W];
  endfunction

  // Every nibble must be a decimal digit and within its digit maximum.
  function automatic logic bcd_legal(
    input logic [31:0] value,
    input logic [31:0] digmax
  );
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (bcd_nib(value, i) > bcd_nib(digmax, i)) ok = 1'b0;
      if (bcd_nib(value, i) > DIG_NINE)           ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/sw_bcd_updown_chain_if.sv
// Control/count bus between the tick logic and the BCD counter.
// master drives controls; slave is the counter side.
interface sw_bcd_updown_chain_if #(
  parameter int NDIG = 4
);
  logic                EN;
  logic                UP;
  logic                CLR;
  logic                LOAD;
  logic [4*NDIG-1:0]   LDVAL;
  logic [4*NDIG-1:0]   BCD;
  logic                CARRY;
  logic                BORROW;
  logic                TC;
  logic                LDERR;

  modport master (
    output EN, UP, CLR, LOAD, LDVAL,
    input  BCD, CARRY, BORROW, TC, LDERR
  );

  modport slave (
    input  EN, UP, CLR, LOAD, LDVAL,
    output BCD, CARRY, BORROW, TC, LDERR
  );
endinterface

// File: rtl/sw_bcd_updown_chain_bcd_digit_cell.sv
// One BCD digit of the ripple up/down chain.
// Steps only when the lower digits rolled over (step-in).
module bcd_digit_cell
  import sw_bcd_pkg::*;
(
  input  logic [3:0] i_cur,
  input  logic [3:0] i_dmax,
  input  logic       i_up,
  input  logic       i_step,
  output logic [3:0] o_nxt,
  output logic       o_step
);

  // Next digit value and roll-over into the next digit.
  always_comb begin
    o_nxt  = i_cur;
    o_step = 1'b0;
    if (i_step) begin
      if (i_up) begin
        if (i_cur == i_dmax) begin
          o_nxt  = DIG_ZERO;
          o_step = 1'b1;
        end else begin
          o_nxt = i_cur + 4'd1;
        end
      end else begin
        if (i_cur == DIG_ZERO) begin
          o_nxt  = i_dmax;
          o_step = 1'b1;
        end else begin
          o_nxt = i_cur - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/sw_bcd_updown_chain.sv
// N-digit mixed-radix BCD up/down counter with wrap or saturate.
// Terminal detect, load validation and output registers live here.
module sw_bcd_updown_chain
  import sw_bcd_pkg::*;
#(
  parameter int                NDIG   = 4,
  parameter logic [4*NDIG-1:0] DIGMAX = 16'h5959,
  parameter logic [4*NDIG-1:0] MAXVAL = 16'h5959,
  parameter logic [4*NDIG-1:0] SETVAL = 16'h0000,
  parameter bit                WRAP   = 1'b1
)(
  input  logic                 CLK1K,
  input  logic                 RST,
  sw_bcd_updown_chain_if.slave bus
);

  localparam int W = 4 * NDIG;

  logic [W-1:0] r_bcd;
  logic         r_carry;
  logic         r_borrow;
  logic         r_lderr;

  logic [W-1:0] w_next;
  logic [NDIG:0] w_step;
  logic         w_at_max;
  logic         w_at_set;
  logic         w_ld_ok;

  assign w_step[0] = 1'b1;

  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    bcd_digit_cell u_cell (
      .i_cur  (r_bcd[4*g +: 4]),
      .i_dmax (bcd_nib(32'(DIGMAX), g)),
      .i_up   (bus.UP),
      .i_step (w_step[g]),
      .o_nxt  (w_next[4*g +: 4]),
      .o_step (w_step[g+1])
    );
  end

  assign w_at_max = (r_bcd == MAXVAL);
  assign w_at_set = (r_bcd == SETVAL);
  assign w_ld_ok  = bcd_legal(32'(bus.LDVAL), 32'(DIGMAX))
                 && (bus.LDVAL >= SETVAL)
                 && (bus.LDVAL <= MAXVAL);

  // Count register and one-cycle pulses; CLR beats LOAD beats EN.
  always_ff @(posedge CLK1K or posedge RST) begin
    if (RST) begin
      r_bcd    <= SETVAL;
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
      r_lderr  <= 1'b0;
    end else begin
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
      r_lderr  <= 1'b0;
      if (bus.CLR) begin
        r_bcd <= SETVAL;
      end else if (bus.LOAD) begin
        if (w_ld_ok) r_bcd   <= bus.LDVAL;
        else         r_lderr <= 1'b1;
      end else if (bus.EN) begin
        if (bus.UP) begin
          if (!w_at_max) begin
            r_bcd <= w_next;
          end else if (WRAP) begin
            r_bcd   <= SETVAL;
            r_carry <= 1'b1;
          end
        end else begin
          if (!w_at_set) begin
            r_bcd <= w_next;
          end else if (WRAP) begin
            r_bcd    <= MAXVAL;
            r_borrow <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.BCD    = r_bcd;
  assign bus.CARRY  = r_carry;
  assign bus.BORROW = r_borrow;
  assign bus.LDERR  = r_lderr;
  assign bus.TC     = bus.UP ? w_at_max : w_at_set;

  // The count never leaves the legal digit set or the terminal range.
  a_range : assert property (
    @(posedge CLK1K) disable iff (RST)
    bcd_legal(32'(r_bcd), 32'(DIGMAX))
      && (r_bcd >= SETVAL) && (r_bcd <= MAXVAL)
  );

endmodule
